// File: rtl/key_reader.sv
// key_reader: sequential read master for the secret-key ROM.
//
// Walks the key ROM from word 0 to KEY_WORDS-1 on a start pulse and streams
// each word to a single consumer over a valid/ready handshake. The ROM has a
// registered address, so the next address is issued in the same cycle the
// current beat is accepted, giving one beat per cycle with no bubbles.
// Key data is forced to zero on out_data whenever out_valid is low, and the
// ROM address is forced to zero whenever the chip enable is inactive.
//
// Optional feature: define KEY_READER_BYTES_EN to emit each word as two
// zero-extended byte beats, low byte first.
//
// Ports:
//   mclk, puc_rst       clock, synchronous active-high reset
//   start, abort        begin a full read / cancel the read in progress
//   busy, done          not idle / one-cycle pulse after the final beat
//   key_addr, key_cen   ROM word address, ROM chip enable (low active)
//   key_dout            ROM read data (valid the cycle after key_cen=0)
//   out_data/valid/ready/last  consumer beat handshake

module key_reader #(
    parameter int unsigned ADDR_MSB  = 4,
    parameter int unsigned KEY_WORDS = 10
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_MSB:0] key_addr,
    output logic              key_cen,
    input  logic [15:0]       key_dout,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int unsigned      AddrW   = ADDR_MSB + 1;
    localparam logic [AddrW-1:0] LastIdx = AddrW'(KEY_WORDS - 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             last_beat;
    logic             word_adv;   // a transfer now completes the current word

`ifdef KEY_READER_BYTES_EN
    logic half_q, half_d;

    assign last_beat = (idx_q == LastIdx) && half_q;
    assign word_adv  = half_q;
`else
    assign last_beat = (idx_q == LastIdx);
    assign word_adv  = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        key_cen  = 1'b1;
        key_addr = '0;
`ifdef KEY_READER_BYTES_EN
        half_d   = half_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    key_cen = 1'b0;
                    state_d = StStream;
                    idx_d   = '0;
`ifdef KEY_READER_BYTES_EN
                    half_d  = 1'b0;
`endif
                end
            end
            StStream: begin
                // abort beats a coincident handshake: no ROM access, no done
                if (abort) begin
                    state_d = StIdle;
`ifdef KEY_READER_BYTES_EN
                    half_d  = 1'b0;
`endif
                end else if (out_ready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
`ifdef KEY_READER_BYTES_EN
                        half_d  = 1'b0;
`endif
                    end else if (word_adv) begin
                        key_cen  = 1'b0;
                        key_addr = idx_q + AddrW'(1);
                        idx_d    = idx_q + AddrW'(1);
`ifdef KEY_READER_BYTES_EN
                        half_d   = 1'b0;
`endif
                    end else begin
`ifdef KEY_READER_BYTES_EN
                        half_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef KEY_READER_BYTES_EN
            half_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef KEY_READER_BYTES_EN
            half_q  <= half_d;
`endif
        end
    end

    assign busy      = (state_q == StStream);
    assign out_valid = (state_q == StStream);
    assign out_last  = out_valid && last_beat;
    assign done      = done_q;

    always_comb begin
        out_data = 16'h0000;
        if (out_valid) begin
`ifdef KEY_READER_BYTES_EN
            out_data = half_q ? {8'h00, key_dout[15:8]} : {8'h00, key_dout[7:0]};
`else
            out_data = key_dout;
`endif
        end
    end

endmodule

// File: tb/tb_key_reader.sv
module tb_key_reader;

`ifdef KEY_READER_BYTES_EN
    localparam int Bpw = 2;
`else
    localparam int Bpw = 1;
`endif
    localparam int KwA = 10;
    localparam int KwB = 1;

    logic        mclk = 1'b0;
    logic        puc_rst, start, abort, out_ready;
    logic        busy, done, key_cen, out_valid, out_last;
    logic [4:0]  key_addr;
    logic [15:0] key_dout, out_data;

    logic        start_b, busy_b, done_b, key_cen_b, out_valid_b, out_last_b;
    logic [4:0]  key_addr_b;
    logic [15:0] key_dout_b, out_data_b;

    always #5 mclk = ~mclk;

    key_reader #(.ADDR_MSB(4), .KEY_WORDS(KwA)) dut_a (
        .mclk(mclk), .puc_rst(puc_rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .key_addr(key_addr), .key_cen(key_cen),
        .key_dout(key_dout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    key_reader #(.ADDR_MSB(4), .KEY_WORDS(KwB)) dut_b (
        .mclk(mclk), .puc_rst(puc_rst), .start(start_b), .abort(1'b0),
        .busy(busy_b), .done(done_b), .key_addr(key_addr_b), .key_cen(key_cen_b),
        .key_dout(key_dout_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(1'b1), .out_last(out_last_b)
    );

    function automatic logic [15:0] word_a(input logic [4:0] a);
        return 16'(32'h1234 * 32'(a));
    endfunction

    function automatic logic [15:0] word_b(input logic [4:0] a);
        return 16'hC3A5 + 16'(a);
    endfunction

    // Registered-address ROM models: data appears the cycle after key_cen=0.
    always @(posedge mclk) if (!key_cen) key_dout <= word_a(key_addr);
    always @(posedge mclk) if (!key_cen_b) key_dout_b <= word_b(key_addr_b);

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          done_cyc = 0;
    int          mb = 0;
    int          t0 = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;
    logic        smp_cen, smp_busy, smp_valid;
    logic [15:0] smp_data;
    logic [16:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_read(input int kw);
        for (int w = 0; w < kw; w++) begin
            logic [15:0] d;
            d = word_a(5'(w));
            if (Bpw == 2) begin
                sb_q.push_back({1'b0, 8'h00, d[7:0]});
                sb_q.push_back({w == kw - 1, 8'h00, d[15:8]});
            end else begin
                sb_q.push_back({w == kw - 1, d});
            end
        end
        mb = 0;
    endtask

    // One clock cycle: sample dut_a at the falling edge, score it, return after the rising edge.
    task automatic tick();
        logic [16:0] e;
        @(negedge mclk);
        #1;
        cyc++;
        smp_cen   = key_cen;
        smp_busy  = busy;
        smp_valid = out_valid;
        smp_data  = out_data;
        if (key_cen) check("addr_zero", 32'(key_addr), 0);
        if (done) begin
            n_done++;
            done_cyc = cyc;
            check("busy_in_done", 32'(busy), 0);
        end
        if (out_valid) begin
            check("busy_stream", 32'(busy), 1);
            if (prev_stall) check("stall_hold", 32'(out_data), 32'(prev_data));
            if (!out_ready || puc_rst) begin
                check("stall_cen", 32'(key_cen), 1);
            end else if (abort) begin
                check("abort_cen", 32'(key_cen), 1);
            end else if (sb_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e[15:0]));
                check("beat_last", 32'(out_last), 32'(e[16]));
                if (!e[16] && (mb % Bpw == Bpw - 1)) begin
                    check("adv_cen", 32'(key_cen), 0);
                    check("adv_addr", 32'(key_addr), 32'(mb / Bpw + 1));
                end else begin
                    check("no_adv_cen", 32'(key_cen), 1);
                end
                mb++;
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
        end else begin
            check("zero_data", 32'(out_data), 0);
            check("idle_last", 32'(out_last), 0);
            prev_stall = 0;
        end
        @(posedge mclk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        n0 = n_done;
        for (int k = 0; k < budget && n_done == n0; k++) tick();
        if (n_done == n0) check("done_timeout", 0, 1);
    endtask

    task automatic begin_read();
        n_done = 0;
        push_read(KwA);
        start = 1'b1;
        tick();
        t0 = cyc;
        check("start_cen", 32'(smp_cen), 0);
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_last"}, 32'(out_last), 0);
        check({tag, "_data"}, 32'(out_data), 0);
        check({tag, "_cen"}, 32'(key_cen), 1);
        check({tag, "_addr"}, 32'(key_addr), 0);
    endtask

    initial begin
        puc_rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; start_b = 1'b0;
        tick();
        tick();
        puc_rst = 1'b0;
        @(negedge mclk);
        #1;
        check_reset_vals("reset");
        @(posedge mclk);
        #1;

        // Full read, consumer always ready.
        out_ready = 1'b1;
        begin_read();
        tick();
        check("first_valid", 32'(smp_valid), 1);
        wait_done(60);
        check("done_latency", 32'(done_cyc - t0), 32'(KwA * Bpw + 1));
        check("sb_empty_1", 32'(sb_q.size()), 0);
        tick();
        check("done_once_1", 32'(n_done), 1);

        // Backpressure 1-0-1-0 with stray start pulses while busy.
        begin_read();
        for (int k = 0; k < 200 && n_done == 0; k++) begin
            out_ready = (k % 2 == 0);
            start = (k == 3 || k == 8);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen_2", 32'(n_done), 1);
        check("sb_empty_2", 32'(sb_q.size()), 0);
        for (int k = 0; k < 4; k++) tick();
        check("done_once_2", 32'(n_done), 1);
        check("idle_after_2", 32'(smp_busy), 0);

        // Abort on the third beat, coinciding with a handshake.
        begin_read();
        for (int k = 0; k < 20 && !(out_valid && mb == 2); k++) tick();
        check("reach_beat3", 32'(mb), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("abort_busy", 32'(smp_busy), 0);
        check("abort_valid", 32'(smp_valid), 0);
        check("abort_data", 32'(smp_data), 0);
        for (int k = 0; k < 30; k++) tick();
        check("abort_no_done", 32'(n_done), 0);
        sb_q.delete();

        // Reset mid-stream, then a fresh read from address 0.
        begin_read();
        for (int k = 0; k < 4; k++) tick();
        out_ready = 1'b0;
        puc_rst = 1'b1;
        tick();
        puc_rst = 1'b0;
        out_ready = 1'b1;
        sb_q.delete();
        @(negedge mclk);
        #1;
        check_reset_vals("midrst");
        @(posedge mclk);
        #1;
        begin_read();
        wait_done(60);
        check("done_latency_4", 32'(done_cyc - t0), 32'(KwA * Bpw + 1));
        check("sb_empty_4", 32'(sb_q.size()), 0);

        // Single-word instance.
        start_b = 1'b1;
        @(negedge mclk);
        #1;
        check("b_start_cen", 32'(key_cen_b), 0);
        check("b_start_addr", 32'(key_addr_b), 0);
        @(posedge mclk);
        #1;
        start_b = 1'b0;
        for (int k = 1; k <= KwB * Bpw; k++) begin
            logic [15:0] w, e;
            w = word_b(5'd0);
            if (Bpw == 2) e = (k == 1) ? {8'h00, w[7:0]} : {8'h00, w[15:8]};
            else          e = w;
            @(negedge mclk);
            #1;
            check("b_valid", 32'(out_valid_b), 1);
            check("b_last", 32'(out_last_b), 32'(k == KwB * Bpw));
            check("b_data", 32'(out_data_b), 32'(e));
            check("b_cen", 32'(key_cen_b), 1);
            check("b_no_done", 32'(done_b), 0);
            @(posedge mclk);
            #1;
        end
        @(negedge mclk);
        #1;
        check("b_done", 32'(done_b), 1);
        check("b_valid_off", 32'(out_valid_b), 0);
        check("b_busy_off", 32'(busy_b), 0);
        @(posedge mclk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
